// File: rtl/run_step_tick_generator.sv
// Tick source for the 0-9 counter: free-running prescaled ticks while RUNNING,
// one tick per debounced step press while PAUSED; run button toggles the mode.
module run_step_tick_generator #(
  parameter int PRESCALE        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit START_RUNNING   = 1'b1
) (
  input  logic clki,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_step,
  output logic enable,
  output logic running
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_PAUSED  = 1'b0;
  localparam logic [0:0] ST_RUNNING = 1'b1;
  localparam logic [0:0] ST_RESET   = START_RUNNING ? ST_RUNNING : ST_PAUSED;

  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;

  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    level_q;
  logic [1:0]    level_d;
  logic [1:0]    level_prev_q;
  logic [1:0]    press_q;
  logic [1:0]    press_d;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [PW-1:0] count_q;
  logic [PW-1:0] count_d;
  logic          enable_q;
  logic          enable_d;
  logic          run_press;
  logic          step_press;

  assign btn_raw = {btn_step, btn_run};

  // Stage 0/1: two-flop synchroniser feeding the debouncers.
  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Stage 2: debounce -- the level only follows after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        level_d[i]  = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end
  end

  // Stage 3: rising-edge detect on the debounced level.
  assign press_d = level_q & ~level_prev_q;

  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      level_q      <= '0;
      level_prev_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= press_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign run_press  = press_q[BTN_RUN];
  assign step_press = press_q[BTN_STEP];

  // Stage 4: mode FSM and prescaler. A run press pre-empts everything in the
  // same cycle, so a coincident step press is dropped and no tick is issued.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    enable_d = 1'b0;
    if (run_press) begin
      state_d = ~state_q;
      count_d = '0;
    end else if (state_q == ST_RUNNING) begin
      if (count_q == PS_LAST) begin
        enable_d = 1'b1;
        count_d  = '0;
      end else begin
        count_d = count_q + PW'(1);
      end
    end else begin
      count_d = '0;
      if (step_press) begin
        enable_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RESET;
      count_q  <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      enable_q <= enable_d;
    end
  end

  assign enable  = enable_q;
  assign running = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_run_step_tick_generator.sv
// Scoreboard bench: stimulus queues the cycle numbers on which enable must
// pulse; a monitor pops and compares every cycle the DUT raises enable.
module tb_run_step_tick_generator;

  localparam int P = 4;
  localparam int D = 3;
  // Button driven right after negedge of cycle b -> press pulse takes effect on edge b+7.
  localparam int LAT = 7;

  logic clk = 1'b0;
  logic reset;
  logic btn_run;
  logic btn_step;
  logic enable;
  logic running;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_q[$];
  logic exp_running;
  logic in_reset;
  int next_tick;
  int trans_at;
  int b;
  logic prev_en = 1'b0;

  run_step_tick_generator #(
    .PRESCALE(P),
    .DEBOUNCE_CYCLES(D),
    .START_RUNNING(1'b1)
  ) dut (
    .clki(clk),
    .reset(reset),
    .btn_run(btn_run),
    .btn_step(btn_step),
    .enable(enable),
    .running(running)
  );

  always #5 clk = ~clk;

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (enable) begin
      total = total + 1;
      if (prev_en) begin
        bad = bad + 1;
        $display("FAIL enable_width cyc=%0d got enable high two cycles in a row, want single-cycle", cyc);
      end else if (exp_q.size() == 0 || exp_q[0] != cyc) begin
        bad = bad + 1;
        $display("FAIL tick_unexpected cyc=%0d got enable=1 want enable=0", cyc);
      end else begin
        void'(exp_q.pop_front());
      end
    end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL tick_missing cyc=%0d got enable=0 want enable=1 at cyc %0d", cyc, exp_q[0]);
      void'(exp_q.pop_front());
    end
    prev_en = enable;
  end

  // Advance n cycles; check running each cycle and queue ticks due on the next edge.
  task automatic adv(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      total = total + 1;
      if (running !== exp_running) begin
        bad = bad + 1;
        $display("FAIL running cyc=%0d got %0b want %0b", cyc, running, exp_running);
      end
      if (!in_reset) begin
        if (trans_at == cyc + 1) begin
          exp_running = ~exp_running;
          if (exp_running) next_tick = cyc + 1 + P;
        end else if (exp_running && next_tick == cyc + 1) begin
          exp_q.push_back(next_tick);
          next_tick = next_tick + P;
        end
      end
    end
  endtask

  task automatic press_run(input int hold, input int after);
    b = cyc;
    btn_run = 1'b1;
    trans_at = b + LAT;
    adv(hold);
    btn_run = 1'b0;
    adv(after);
  endtask

  initial begin
    reset = 1'b1;
    btn_run = 1'b0;
    btn_step = 1'b0;
    exp_running = 1'b1;
    in_reset = 1'b1;
    next_tick = -1;
    trans_at = -1;

    // Test 1: cadence from reset release.
    adv(3);
    reset = 1'b0;
    in_reset = 1'b0;
    next_tick = cyc + P;
    adv(14);

    // Test 2: short glitch is ignored; long press pauses.
    btn_run = 1'b1;
    adv(2);
    btn_run = 1'b0;
    adv(10);
    press_run(10, 8);

    // Test 3: step in PAUSED gives one tick; a 1-cycle glitch gives none.
    b = cyc;
    btn_step = 1'b1;
    adv(LAT - 1);
    exp_q.push_back(b + LAT);
    adv(4);
    btn_step = 1'b0;
    adv(8);
    btn_step = 1'b1;
    adv(1);
    btn_step = 1'b0;
    adv(10);

    // Test 4: back to RUNNING, step press must not disturb the phase.
    press_run(10, 6);
    btn_step = 1'b1;
    adv(10);
    btn_step = 1'b0;
    adv(10);

    // Test 5: pause, then run+step together from PAUSED -> run wins, no step tick.
    press_run(10, 6);
    b = cyc;
    btn_run = 1'b1;
    btn_step = 1'b1;
    trans_at = b + LAT;
    adv(12);
    btn_run = 1'b0;
    btn_step = 1'b0;
    adv(12);

    // Test 6: async reset while enable is high, then cadence restarts.
    while (next_tick != cyc + 1 + P) adv(1);
    adv(1);
    total = total + 1;
    if (enable !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL pre_reset_tick cyc=%0d got enable=%0b want 1", cyc, enable);
    end
    #2;
    reset = 1'b1;
    in_reset = 1'b1;
    exp_running = 1'b1;
    trans_at = -1;
    #1;
    total = total + 1;
    if (enable !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL async_reset_enable got %0b want 0", enable);
    end
    total = total + 1;
    if (running !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL async_reset_running got %0b want 1", running);
    end
    adv(4);
    reset = 1'b0;
    in_reset = 1'b0;
    next_tick = cyc + P;
    adv(14);

    adv(2);
    while (exp_q.size() > 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL tick_never_seen got none want enable at cyc %0d", exp_q[0]);
      void'(exp_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
